bldc_quadencoder: RTL and testbench

- Upstream feedback stage for the bldc commutation block.
- Decodes a filtered quadrature encoder (A/B/Z) into the 12-bit signed rotor position that bldc consumes on its `feedback` input.
- Provides index-based zeroing and illegal-transition detection, so commutation can be aligned to the rotor index mark.
- Single clock domain, shared with bldc; encoder pins are asynchronous.

---
 rtl/bldc_quadencoder_if.sv | 21 ++
 rtl/bldc_quadencoder.sv | 132 +++++++++++++
 tb/tb_bldc_quadencoder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_quadencoder_if.sv
// Encoder pins in, rotor position and status out, between the encoder front end and the bldc feedback path.
interface bldc_quadencoder_if;
  logic               a;
  logic               b;
  logic               z;
  logic               index_enable;
  logic               error_clear;
  logic signed [11:0] feedback;
  logic               index_seen;
  logic               error;

  modport master (
    output a, b, z, index_enable, error_clear,
    input  feedback, index_seen, error
  );

  modport slave (
    input  a, b, z, index_enable, error_clear,
    output feedback, index_seen, error
  );
endinterface

// File: rtl/bldc_quadencoder.sv
// Quadrature A/B/Z decoder: 2-flop sync, FILTER-sample glitch filter, x4 count, index reload, sticky error.
// Latency FILTER+3 edges from pin to feedback; no backpressure, the position register is always valid.
module bldc_quadencoder #(
  parameter int unsigned        FILTER      = 3,
  parameter logic signed [11:0] INDEX_VALUE = 12'sd0,
  parameter bit                 DIRECTION   = 1'b0
) (
  input logic                clk,
  input logic                rst,
  bldc_quadencoder_if.slave  enc
);

  localparam logic [3:0] FILT = 4'(FILTER);

  // Channel bit order everywhere: [2]=A, [1]=B, [0]=Z.
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [2:0]         lvl_q, lvl_d;
  logic [3:0]         cnt_q [3];
  logic [3:0]         cnt_d [3];
  logic               armed_q, armed_d;
  logic [1:0]         ab_prev_q, ab_prev_d;
  logic               z_prev_q, z_prev_d;
  logic signed [11:0] fb_q, fb_d;
  logic               idx_q, idx_d;
  logic               err_q, err_d;

  logic [1:0] dlt;
  logic       z_qual;
  logic       count_up;

  // Gray {A,B} to position within the forward cycle 00,10,11,01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    sync1_d   = {enc.a, enc.b, enc.z};
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    ab_prev_d = ab_prev_q;
    z_prev_d  = lvl_q[0];
    fb_d      = fb_q;
    idx_d     = idx_q;
    err_d     = err_q;

    for (int ch = 0; ch < 3; ch++) begin
      if (!armed_q && ch != 0) begin
        // Before arming A/B levels follow the sample and the counter measures how long it has been steady.
        if (sync2_q[ch] != lvl_q[ch]) begin
          lvl_d[ch] = sync2_q[ch];
          cnt_d[ch] = 4'd1;
        end else if (cnt_q[ch] != FILT) begin
          cnt_d[ch] = cnt_q[ch] + 4'd1;
        end
      end else begin
        if (sync2_q[ch] == lvl_q[ch]) begin
          cnt_d[ch] = 4'd0;
        end else if (cnt_q[ch] + 4'd1 == FILT) begin
          lvl_d[ch] = sync2_q[ch];
          cnt_d[ch] = 4'd0;
        end else begin
          cnt_d[ch] = cnt_q[ch] + 4'd1;
        end
      end
    end

    if (!armed_q && cnt_q[2] == FILT && cnt_q[1] == FILT) begin
      armed_d   = 1'b1;
      ab_prev_d = lvl_q[2:1];
      lvl_d[2]  = lvl_q[2];
      lvl_d[1]  = lvl_q[1];
      cnt_d[2]  = 4'd0;
      cnt_d[1]  = 4'd0;
    end

    dlt      = phase_of(lvl_q[2:1]) - phase_of(ab_prev_q);
    z_qual   = armed_q && enc.index_enable && lvl_q[0] && !z_prev_q;
    count_up = (dlt == 2'd1) ^ DIRECTION;

    if (enc.error_clear) begin
      err_d = 1'b0;
    end

    if (armed_q) begin
      ab_prev_d = lvl_q[2:1];
      if (dlt == 2'd2) begin
        err_d = 1'b1;
      end
      // A qualified index wins over an A/B step seen in the same cycle.
      if (z_qual) begin
        fb_d  = INDEX_VALUE;
        idx_d = 1'b1;
      end else if (dlt == 2'd1 || dlt == 2'd3) begin
        fb_d = count_up ? fb_q + 12'sd1 : fb_q - 12'sd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      cnt_q     <= '{default: '0};
      armed_q   <= 1'b0;
      ab_prev_q <= '0;
      z_prev_q  <= 1'b0;
      fb_q      <= '0;
      idx_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      ab_prev_q <= ab_prev_d;
      z_prev_q  <= z_prev_d;
      fb_q      <= fb_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign enc.feedback   = fb_q;
  assign enc.index_seen = idx_q;
  assign enc.error      = err_q;

endmodule

// File: tb/tb_bldc_quadencoder.sv
// Drives quadrature sequences into bldc_quadencoder; expected outputs come from a phase/position model
// and are queued with the cycle they must appear, then a negedge monitor pops and compares them.
module tb_bldc_quadencoder;
  localparam int                 FILTER  = 3;
  localparam int                 LAT     = FILTER + 3;
  localparam logic signed [11:0] IDX_VAL = 12'sd100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bldc_quadencoder_if enc();

  bldc_quadencoder #(
    .FILTER      (FILTER),
    .INDEX_VALUE (IDX_VAL),
    .DIRECTION   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .enc (enc)
  );

  typedef struct {
    int                 due;
    logic signed [11:0] fb;
    logic               err;
    logic               idx;
    string              name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: position as a plain integer, encoder phase as an index into the forward cycle.
  int         pos   = 0;
  int         phase = 2;
  bit         m_err = 1'b0;
  bit         m_idx = 1'b0;
  logic [1:0] seq [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.due != cyc || enc.feedback !== mon_e.fb ||
          enc.error !== mon_e.err || enc.index_seen !== mon_e.idx) begin
        errors++;
        $display("FAIL %s at cycle %0d (due %0d): got feedback=%0d error=%0b index_seen=%0b, want feedback=%0d error=%0b index_seen=%0b",
                 mon_e.name, cyc, mon_e.due, enc.feedback, enc.error, enc.index_seen,
                 mon_e.fb, mon_e.err, mon_e.idx);
      end
    end
  end

  function automatic void push(int due, string nm);
    exp_t e;
    int   i;
    e.due  = due;
    e.fb   = 12'(pos);
    e.err  = m_err;
    e.idx  = m_idx;
    e.name = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].due > due) i--;
    sb.insert(i, e);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_ab();
    enc.a = seq[phase][1];
    enc.b = seq[phase][0];
  endtask

  task automatic step(bit fwd, int hold, string nm);
    phase = (phase + (fwd ? 1 : 3)) % 4;
    pos   = pos + (fwd ? 1 : -1);
    drive_ab();
    push(cyc + LAT, nm);
    tick(hold);
  endtask

  task automatic illegal(string nm);
    phase = (phase + 2) % 4;
    m_err = 1'b1;
    drive_ab();
    push(cyc + LAT, nm);
    tick(10);
  endtask

  task automatic clear_err(string nm);
    enc.error_clear = 1'b1;
    m_err = 1'b0;
    push(cyc + 1, nm);
    tick(1);
    enc.error_clear = 1'b0;
    tick(4);
  endtask

  task automatic glitch(bit on_a, int len);
    if (on_a) enc.a = ~enc.a; else enc.b = ~enc.b;
    tick(len);
    drive_ab();
    tick(10);
    push(cyc + 1, "glitch");
    tick(2);
  endtask

  task automatic goto_pos(int target);
    int d;
    d = (target - pos) & 4095;
    if (d <= 2048) begin
      repeat (d) step(1'b1, 5, "walk_fwd");
    end else begin
      repeat (4096 - d) step(1'b0, 5, "walk_rev");
    end
    tick(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int w;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    enc.a = 1'b1; enc.b = 1'b1; enc.z = 1'b0;
    enc.index_enable = 1'b0; enc.error_clear = 1'b0;
    phase = 2;

    // Reset with A=B=1: arming must not produce a count.
    tick(3);
    rst = 1'b0;
    push(cyc + 1, "reset_state");
    push(cyc + 20, "armed_no_count");
    tick(25);

    // Forward run with exact first-step latency, then reverse.
    push(cyc + LAT - 1, "latency_before");
    step(1'b1, 10, "fwd_first");
    repeat (7) step(1'b1, 10, "fwd");
    repeat (3) step(1'b0, 10, "rev");

    glitch(1'b1, 2);
    glitch(1'b0, 1);
    glitch(1'b1, 1);
    glitch(1'b0, FILTER - 1);

    illegal("illegal");
    clear_err("err_clear");

    // Clear lands on the same edge the illegal transition is decoded.
    phase = (phase + 2) % 4;
    m_err = 1'b1;
    drive_ab();
    push(cyc + LAT, "clear_vs_set");
    push(cyc + LAT + 3, "clear_vs_set_hold");
    tick(LAT - 1);
    enc.error_clear = 1'b1;
    tick(1);
    enc.error_clear = 1'b0;
    tick(6);
    clear_err("err_clear2");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch(1'($urandom_range(0, 1)), $urandom_range(1, FILTER - 1));
      end else if (r == 1) begin
        illegal("rand_illegal");
        clear_err("rand_clear");
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(FILTER + 2, 12), "rand_step");
      end
    end

    // Index: disabled edge ignored, enabled edge reloads, index beats a coincident step.
    goto_pos(37);
    enc.z = 1'b1;
    push(cyc + LAT + 2, "z_disabled");
    tick(12);
    enc.z = 1'b0;
    tick(10);
    enc.index_enable = 1'b1;
    tick(2);
    enc.z = 1'b1;
    push(cyc + LAT - 1, "index_before");
    pos   = int'(IDX_VAL);
    m_idx = 1'b1;
    push(cyc + LAT, "index_load");
    tick(12);
    enc.z = 1'b0;
    tick(10);
    step(1'b1, 10, "post_index_step");
    enc.z = 1'b1;
    phase = (phase + 1) % 4;
    pos   = int'(IDX_VAL);
    drive_ab();
    push(cyc + LAT, "index_vs_step");
    tick(12);
    enc.z = 1'b0;
    tick(10);
    enc.index_enable = 1'b0;

    // Error stays set while counting continues, then reset mid-step clears everything.
    illegal("illegal_keep");
    goto_pos(500);
    phase = (phase + 1) % 4;
    drive_ab();
    tick(2);
    rst   = 1'b1;
    pos   = 0;
    m_err = 1'b0;
    m_idx = 1'b0;
    push(cyc + 1, "reset_mid");
    tick(1);
    rst = 1'b0;
    push(cyc + 15, "reset_no_inflight");
    tick(20);
    step(1'b1, 10, "after_rearm");

    // Positive wrap through 2047 -> -2048.
    goto_pos(2046);
    repeat (4) step(1'b1, 10, "wrap_fwd");

    w = 0;
    while (sb.size() > 0 && w < 50) begin
      tick(1);
      w++;
    end
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation due at cycle %0d never checked (cycle now %0d)", mon_e.name, mon_e.due, cyc);
    end

    checks++;
    if (enc.feedback !== 12'(pos)) begin
      errors++;
      $display("FAIL final_feedback: got %0d want %0d", enc.feedback, 12'(pos));
    end
    checks++;
    if (enc.error !== m_err) begin
      errors++;
      $display("FAIL final_error: got %0b want %0b", enc.error, m_err);
    end
    checks++;
    if (enc.index_seen !== m_idx) begin
      errors++;
      $display("FAIL final_index_seen: got %0b want %0b", enc.index_seen, m_idx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
